// File: rtl/itch_message_dispatcher.sv
// ITCH feed front end: frames messages from a 64-bit word stream and routes each body to its field parser.
// Optional build macro ITCH_DISPATCH_STATS_EN adds msgCount/skipCount message counters.
module itch_message_dispatcher #(
    parameter int                       NUM_PARSERS = 8,
    parameter logic [NUM_PARSERS*8-1:0] TYPE_CODES  = {"L", "R", "T", "A", "D", "E", "U", "X"},
    parameter logic [15:0]              MAX_LEN     = 16'd512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            dataIn,
    input  logic                   dataValid,
    output logic                   dataReady,
    output logic [63:0]            parserData,
    output logic [NUM_PARSERS-1:0] parserStart,
    output logic [NUM_PARSERS-1:0] parserSel,
    output logic [5:0]             trackerOut,
    output logic                   msgLast,
`ifdef ITCH_DISPATCH_STATS_EN
    output logic                   frameErr,
    output logic [31:0]            msgCount,
    output logic [31:0]            skipCount
`else
    output logic                   frameErr
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_SKIP} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               ptr_q, ptr_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [15:0]              hbuf_q, hbuf_d;
    logic [15:0]              rem_q, rem_d;
    logic [NUM_PARSERS-1:0]   sel_q, sel_d;
    logic                     pend_q, pend_d;
    logic [63:0]              hold_q, hold_d;
    logic                     rescan_q, rescan_d;
    logic                     ready_q, ready_d;
    logic                     ferr_q, ferr_d;
    logic [63:0]              parser_data_q, parser_data_d;
    logic [NUM_PARSERS-1:0]   start_q, start_d;
    logic [NUM_PARSERS-1:0]   psel_q, psel_d;
    logic [5:0]               tracker_q, tracker_d;
    logic                     last_q, last_d;

    logic [63:0]              word;
    logic                     act;
    logic                     in_hdr;
    logic [1:0]               cnt;
    logic [3:0]               ptr;
    logic [7:0]               hb0, hb1, hb2;
    logic [3:0]               hdr_end;
    logic                     hdr_done;
    logic [15:0]              len;
    logic                     len_bad;
    logic [NUM_PARSERS-1:0]   hit_vec;
    logic                     body_go;
    logic [3:0]               b_start;
    logic [15:0]              b_rem;
    logic                     b_hit;
    logic [NUM_PARSERS-1:0]   b_sel;
    logic                     b_first;
    logic [3:0]               avail;
    logic                     b_end;
    logic [3:0]               p2;
    logic                     emit;

    function automatic logic [7:0] get_byte(input logic [63:0] w, input logic [3:0] idx);
        get_byte = (idx < 4'd8) ? w[{idx[2:0], 3'b000} +: 8] : 8'h00;
    endfunction

    function automatic logic [15:0] sub_sat(input logic [15:0] a, input logic [15:0] b);
        sub_sat = (a > b) ? (a - b) : 16'd0;
    endfunction

    // A held word is re-scanned when a header completes right after a message end in the same word.
    assign word = rescan_q ? hold_q : dataIn;
    assign act  = rescan_q || (ready_q && dataValid);

    always_comb begin : scan
        in_hdr  = (state_q == S_IDLE) || (state_q == S_HDR);
        cnt     = (state_q == S_IDLE) ? 2'd0 : cnt_q;
        ptr     = (state_q == S_IDLE) ? 4'd0 : ptr_q;
        hb0     = (cnt != 2'd0) ? hbuf_q[7:0] : get_byte(word, ptr);
        hb1     = (cnt == 2'd2) ? hbuf_q[15:8]
                : get_byte(word, (cnt == 2'd1) ? ptr : ptr + 4'd1);
        hb2     = get_byte(word, ptr + 4'd2 - {2'b00, cnt});
        hdr_end = ptr + 4'd3 - {2'b00, cnt};
        hdr_done = in_hdr && (hdr_end <= 4'd8);
        len     = {hb0, hb1};
        len_bad = (len == 16'd0) || (len > MAX_LEN);
        for (int i = 0; i < NUM_PARSERS; i++) begin
            hit_vec[i] = (TYPE_CODES[8*(NUM_PARSERS-1-i) +: 8] == hb2);
        end
        body_go = in_hdr ? (hdr_done && !len_bad) : 1'b1;
        b_start = in_hdr ? hdr_end : ptr_q;
        b_rem   = in_hdr ? (len - 16'd1) : rem_q;
        b_hit   = in_hdr ? (|hit_vec) : (state_q == S_BODY);
        b_sel   = in_hdr ? hit_vec : sel_q;
        b_first = in_hdr ? 1'b1 : pend_q;
        avail   = 4'd8 - b_start;
        b_end   = body_go && ({12'd0, avail} >= b_rem);
        p2      = b_start + b_rem[3:0];
        // A type byte in the last slot of a word defers the start beat to the next word.
        emit    = act && body_go && b_hit && (b_end || (avail != 4'd0));
    end

    always_comb begin : next_state
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        hbuf_d   = hbuf_q;
        rem_d    = rem_q;
        sel_d    = sel_q;
        pend_d   = pend_q;
        ferr_d   = ferr_q;
        hold_d   = hold_q;
        rescan_d = 1'b0;
        if (act) begin
            hold_d = word;
            if (in_hdr && !hdr_done) begin
                state_d = S_HDR;
                ptr_d   = 4'd0;
                cnt_d   = cnt + 2'(4'd8 - ptr);
                if (cnt == 2'd0) begin
                    hbuf_d = {get_byte(word, ptr + 4'd1), get_byte(word, ptr)};
                end else begin
                    hbuf_d[15:8] = get_byte(word, ptr);
                end
            end else if (in_hdr && len_bad) begin
                state_d = S_IDLE;
                ptr_d   = 4'd0;
                cnt_d   = 2'd0;
                ferr_d  = 1'b1;
            end else if (!b_end) begin
                state_d = b_hit ? S_BODY : S_SKIP;
                ptr_d   = 4'd0;
                cnt_d   = 2'd0;
                rem_d   = sub_sat(b_rem, {12'd0, avail});
                sel_d   = b_sel;
                pend_d  = b_hit && b_first && !emit;
            end else begin
                state_d = S_HDR;
                ptr_d   = 4'd0;
                cnt_d   = 2'd0;
                pend_d  = 1'b0;
                rem_d   = 16'd0;
                if (p2 <= 4'd5) begin
                    ptr_d    = p2;
                    rescan_d = 1'b1;
                end else if (p2 < 4'd8) begin
                    cnt_d  = 2'(4'd8 - p2);
                    hbuf_d = {get_byte(word, p2 + 4'd1), get_byte(word, p2)};
                end
            end
        end
        ready_d = !rescan_d;
    end

    always_comb begin : outputs
        parser_data_d = act ? word : parser_data_q;
        psel_d        = emit ? b_sel : '0;
        start_d       = (emit && b_first) ? b_sel : '0;
        tracker_d     = (emit && b_first) ? {b_start[2:0], 3'b000} : 6'd0;
        last_d        = emit && b_end;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= 4'd0;
            cnt_q         <= 2'd0;
            hbuf_q        <= 16'd0;
            rem_q         <= 16'd0;
            sel_q         <= '0;
            pend_q        <= 1'b0;
            hold_q        <= 64'd0;
            rescan_q      <= 1'b0;
            ready_q       <= 1'b0;
            ferr_q        <= 1'b0;
            parser_data_q <= 64'd0;
            start_q       <= '0;
            psel_q        <= '0;
            tracker_q     <= 6'd0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            hbuf_q        <= hbuf_d;
            rem_q         <= rem_d;
            sel_q         <= sel_d;
            pend_q        <= pend_d;
            hold_q        <= hold_d;
            rescan_q      <= rescan_d;
            ready_q       <= ready_d;
            ferr_q        <= ferr_d;
            parser_data_q <= parser_data_d;
            start_q       <= start_d;
            psel_q        <= psel_d;
            tracker_q     <= tracker_d;
            last_q        <= last_d;
        end
    end

    assign dataReady   = ready_q;
    assign parserData  = parser_data_q;
    assign parserStart = start_q;
    assign parserSel   = psel_q;
    assign trackerOut  = tracker_q;
    assign msgLast     = last_q;
    assign frameErr    = ferr_q;

`ifdef ITCH_DISPATCH_STATS_EN
    logic [31:0] msg_count_q, msg_count_d;
    logic [31:0] skip_count_q, skip_count_d;

    always_comb begin
        msg_count_d  = msg_count_q;
        skip_count_d = skip_count_q;
        if (act && in_hdr && hdr_done && !len_bad) begin
            if (|hit_vec) msg_count_d  = msg_count_q + 32'd1;
            else          skip_count_d = skip_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_count_q  <= 32'd0;
            skip_count_q <= 32'd0;
        end else begin
            msg_count_q  <= msg_count_d;
            skip_count_q <= skip_count_d;
        end
    end

    assign msgCount  = msg_count_q;
    assign skipCount = skip_count_q;
`endif

endmodule

// File: tb/tb_itch_message_dispatcher.sv
// Directed bench for itch_message_dispatcher: a hand-built feed stream with a table of expected output beats.
module tb_itch_message_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] dataIn = 64'd0;
    logic        dataValid = 1'b0;
    logic        dataReady;
    logic [63:0] parserData;
    logic [7:0]  parserStart;
    logic [7:0]  parserSel;
    logic [5:0]  trackerOut;
    logic        msgLast;
    logic        frameErr;
`ifdef ITCH_DISPATCH_STATS_EN
    logic [31:0] msgCount;
    logic [31:0] skipCount;
`endif

    itch_message_dispatcher dut (
        .clk(clk), .rst(rst), .dataIn(dataIn), .dataValid(dataValid), .dataReady(dataReady),
        .parserData(parserData), .parserStart(parserStart), .parserSel(parserSel),
        .trackerOut(trackerOut), .msgLast(msgLast),
`ifdef ITCH_DISPATCH_STATS_EN
        .msgCount(msgCount), .skipCount(skipCount),
`endif
        .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  st;
        logic [7:0]  sel;
        logic [5:0]  tr;
        logic        last;
        logic [63:0] data;
    } beat_t;
    beat_t log_q[$];

    always @(negedge clk) begin
        if (parserSel != 8'h00 || parserStart != 8'h00 || msgLast) begin
            log_q.push_back('{cyc, parserStart, parserSel, trackerOut, msgLast, parserData});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wb(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic send(input logic [63:0] w, output int waits, output int acc);
        waits = 0;
        dataIn = w;
        dataValid = 1'b1;
        while (dataReady !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) chk("ready_timeout", 64'(waits), 64'd0);
        acc = cyc + 1;
        @(negedge clk);
        dataValid = 1'b0;
    endtask

    // Expected output beats: start, sel, tracker, last.
    logic [7:0] e_st  [17] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h08, 8'h00, 8'h20, 8'h80,
                               8'h04, 8'h02, 8'h10, 8'h10, 8'h40, 8'h00, 8'h01, 8'h20};
    logic [7:0] e_sel [17] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h10, 8'h08, 8'h08, 8'h20, 8'h80,
                               8'h04, 8'h02, 8'h10, 8'h10, 8'h40, 8'h40, 8'h01, 8'h20};
    logic [5:0] e_tr  [17] = '{6'd24, 6'd0, 6'd0, 6'd0, 6'd48, 6'd16, 6'd0, 6'd16, 6'd24,
                               6'd0, 6'd48, 6'd24, 6'd56, 6'd24, 6'd0, 6'd8, 6'd24};
    logic       e_last[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [63:0] wv [15];
    int waits [15];
    int acc [15];

    initial begin
        wv[0]  = wb(8'h00, 8'h19, "L",   8'h11, 8'h12, 8'h13, 8'h14, 8'h15);
        wv[1]  = 64'hA8A7A6A5A4A3A2A1;
        wv[2]  = 64'hB8B7B6B5B4B3B2B1;
        wv[3]  = wb(8'h21, 8'h22, 8'h23, 8'h00, 8'h02, "D",   8'h31, 8'h00);
        wv[4]  = wb(8'h0A, "A",   8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46);
        wv[5]  = wb(8'h47, 8'h48, 8'h49, 8'h00, 8'h0A, "Z",   8'h51, 8'h52);
        wv[6]  = wb(8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h00);
        wv[7]  = wb(8'h02, "E",   8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wv[8]  = wb(8'h00, 8'h03, "X",   8'hC1, 8'hC2, 8'h00, 8'h04, "T");
        wv[9]  = wb(8'h61, 8'h62, 8'h63, 8'h00, 8'h03, "R",   8'h64, 8'h65);
        wv[10] = wb(8'h00, 8'h02, "D",   8'h71, 8'h00, 8'h02, "D",   8'h72);
        wv[11] = wb(8'h00, 8'h0C, "U",   8'h81, 8'h82, 8'h83, 8'h84, 8'h85);
        wv[12] = wb(8'h86, 8'h87, 8'h88, 8'h89, 8'h8A, 8'h8B, 8'h00, 8'h09);
        wv[13] = wb("L",   8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97);
        wv[14] = wb(8'h00, 8'h06, "E",   8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5);

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(dataReady), 64'd0);
        chk("rst_outs", 64'({parserStart, parserSel, trackerOut, msgLast}), 64'd0);
        chk("rst_data", parserData, 64'd0);
        chk("rst_ferr", 64'(frameErr), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_rise", 64'(dataReady), 64'd1);

        for (int i = 0; i <= 6; i++) send(wv[i], waits[i], acc[i]);
        chk("ferr_before", 64'(frameErr), 64'd0);
        for (int i = 7; i <= 11; i++) send(wv[i], waits[i], acc[i]);
        chk("ferr_set", 64'(frameErr), 64'd1);
        repeat (3) @(negedge clk);
        send(wv[12], waits[12], acc[12]);
        send(wv[13], waits[13], acc[13]);
        chk("ferr_sticky", 64'(frameErr), 64'd1);
        chk("mid_body_sel", 64'(parserSel), 64'h01);
`ifdef ITCH_DISPATCH_STATS_EN
        chk("skip_count", 64'(skipCount), 64'd1);
        chk("msg_count", 64'(msgCount), 64'd11);
`endif

        #2 rst = 1'b0;
        #1;
        chk("arst_outs", 64'({parserStart, parserSel, trackerOut, msgLast, dataReady, frameErr}), 64'd0);
        chk("arst_data", parserData, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        send(wv[14], waits[14], acc[14]);
        @(negedge clk);
        @(negedge clk);
`ifdef ITCH_DISPATCH_STATS_EN
        chk("msg_count_after_rst", 64'(msgCount), 64'd1);
`endif

        chk("w1_no_stall", 64'(waits[1]), 64'd0);
        chk("w11_one_stall", 64'(waits[11]), 64'd1);
        chk("beat_count", 64'(log_q.size()), 64'd17);
        for (int i = 0; i < 17 && i < log_q.size(); i++) begin
            chk($sformatf("beat%0d", i),
                64'({log_q[i].st, log_q[i].sel, log_q[i].tr, log_q[i].last}),
                64'({e_st[i], e_sel[i], e_tr[i], e_last[i]}));
        end
        if (log_q.size() >= 17) begin
            chk("first_beat_latency", 64'(log_q[0].cyc), 64'(acc[0]));
            chk("first_beat_data", log_q[0].data, wv[0]);
            chk("rescan_d_adjacent", 64'(log_q[12].cyc), 64'(log_q[11].cyc + 1));
            chk("rescan_d_data0", log_q[11].data, wv[10]);
            chk("rescan_d_data1", log_q[12].data, wv[10]);
            chk("rescan_ad_adjacent", 64'(log_q[4].cyc), 64'(log_q[3].cyc + 1));
            chk("after_rst_data", log_q[16].data, wv[14]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
